// File: rtl/uart_send.sv
// uart_send: 8N1/8N2 UART transmitter with a small input FIFO.
// Bits are timed from sys_clk running at OVERSAMPLE x baud. Frames are
// sent LSB first, and a queued byte starts the next frame on the cycle
// right after the last stop cycle, so bursts leave with no idle gap.
module uart_send #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int STOP_BITS  = 1
) (
  input  logic                              sys_clk,
  input  logic                              rst,
  input  logic [7:0]                        in_dat,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic                              txd,
  output logic                              busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CYC_W = $clog2(OVERSAMPLE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t             r_state;
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wrPtr;
  logic [PTR_W-1:0]   r_rdPtr;
  logic [CNT_W-1:0]   r_count;
  logic [7:0]         r_shift;
  logic [CYC_W-1:0]   r_cycCnt;
  logic [2:0]         r_bitCnt;
  logic               r_stopCnt;
  logic               r_txd;
  logic               r_busy;

  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_cycLast;
  logic               w_stopLast;
  logic               w_stopDone;
  logic               w_nextIdle;
  logic [CNT_W-1:0]   w_countNext;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_push     = in_valid && !w_full;
  assign w_cycLast  = (r_cycCnt == CYC_W'(OVERSAMPLE - 1));
  assign w_stopLast = (r_stopCnt == 1'(STOP_BITS - 1));
  assign w_stopDone = (r_state == S_STOP) && w_cycLast && w_stopLast;

  // The FSM takes the head byte when idle or at the end of the stop interval.
  assign w_pop      = !w_empty && ((r_state == S_IDLE) || w_stopDone);

  // The FSM will sit in IDLE after this edge only if there is nothing to send.
  assign w_nextIdle = w_empty && ((r_state == S_IDLE) || w_stopDone);

  assign in_ready   = !w_full;
  assign txd        = r_txd;
  assign busy       = r_busy;
  assign fifo_count = r_count;

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + CNT_W'(1);
      2'b01:   w_countNext = r_count - CNT_W'(1);
      default: w_countNext = r_count;
    endcase
  end

  // FIFO storage; stale entries are harmless because the pointers reset.
  always_ff @(posedge sys_clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= in_dat;
    end
  end

  // FIFO pointers and occupancy count; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= w_countNext;
    end
  end

  // Busy reflects the state and occupancy that this edge is about to establish.
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_busy <= 1'b0;
    end else begin
      r_busy <= !w_nextIdle || (w_countNext != '0);
    end
  end

  // Transmit FSM: start bit, eight data bits LSB first, then stop bit(s).
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_cycCnt  <= '0;
      r_bitCnt  <= '0;
      r_stopCnt <= 1'b0;
      r_txd     <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_txd <= 1'b1;
          if (!w_empty) begin
            r_shift   <= r_mem[r_rdPtr];
            r_cycCnt  <= '0;
            r_bitCnt  <= '0;
            r_stopCnt <= 1'b0;
            r_txd     <= 1'b0;
            r_state   <= S_START;
          end
        end

        S_START: begin
          if (w_cycLast) begin
            r_cycCnt <= '0;
            r_bitCnt <= '0;
            r_txd    <= r_shift[0];
            r_state  <= S_DATA;
          end else begin
            r_cycCnt <= r_cycCnt + CYC_W'(1);
          end
        end

        S_DATA: begin
          if (w_cycLast) begin
            r_cycCnt <= '0;
            if (r_bitCnt == 3'd7) begin
              r_stopCnt <= 1'b0;
              r_txd     <= 1'b1;
              r_state   <= S_STOP;
            end else begin
              r_bitCnt <= r_bitCnt + 3'd1;
              r_shift  <= {1'b0, r_shift[7:1]};
              r_txd    <= r_shift[1];
            end
          end else begin
            r_cycCnt <= r_cycCnt + CYC_W'(1);
          end
        end

        S_STOP: begin
          if (w_cycLast) begin
            r_cycCnt <= '0;
            if (w_stopLast) begin
              r_stopCnt <= 1'b0;
              if (!w_empty) begin
                r_shift  <= r_mem[r_rdPtr];
                r_bitCnt <= '0;
                r_txd    <= 1'b0;
                r_state  <= S_START;
              end else begin
                r_txd   <= 1'b1;
                r_state <= S_IDLE;
              end
            end else begin
              r_stopCnt <= r_stopCnt + 1'b1;
            end
          end else begin
            r_cycCnt <= r_cycCnt + CYC_W'(1);
          end
        end

        default: begin
          r_txd   <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// tb_uart_send: randomized and directed stimulus for uart_send, checked by a
// time-based reference model (FIFO occupancy plus "transmitter free at edge N")
// feeding a scoreboard that a serial-line monitor consumes frame by frame.
module tb_uart_send;

  localparam int OS     = 16;
  localparam int DEPTH  = 4;
  localparam int FRAME1 = (9 + 1) * OS;
  localparam int FRAME2 = (9 + 2) * OS;

  typedef struct {
    logic [7:0] dat;
    int         startEdge;
  } exp_t;

  logic       sys_clk = 1'b0;
  logic       rst;
  logic [7:0] inDat;
  logic       inValid;
  logic       inReady;
  logic       txd;
  logic       busy;
  logic [2:0] fifoCount;

  logic [7:0] inDat2;
  logic       inValid2;
  logic       inReady2;
  logic       txd2;
  logic       busy2;
  logic [2:0] fifoCount2;

  int checks     = 0;
  int failures   = 0;
  int edgeNo     = 0;
  int mCnt       = 0;
  int txFreeAt   = 0;
  int lastPop    = 0;
  int framesSeen = 0;
  logic [7:0] mFifo[$];
  exp_t       sb[$];
  int         startLog[$];
  bit         rec2 = 0;
  logic       hist2[$];

  always #5 sys_clk = ~sys_clk;

  uart_send #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .in_dat     (inDat),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .txd        (txd),
    .busy       (busy),
    .fifo_count (fifoCount)
  );

  uart_send #(.OVERSAMPLE(OS), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .in_dat     (inDat2),
    .in_valid   (inValid2),
    .in_ready   (inReady2),
    .txd        (txd2),
    .busy       (busy2),
    .fifo_count (fifoCount2)
  );

  // One comparison: count it, and report it when it differs.
  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (edge %0d)", name, actual, expected, edgeNo);
    end
  endtask

  // Drive one cycle of inputs, advance the reference model across the edge,
  // then compare the registered status outputs against the model.
  task automatic applyStimulus(input logic v, input logic [7:0] d,
                               input logic v2, input logic [7:0] d2);
    bit doPop;
    bit doPush;
    inValid  = v;
    inDat    = d;
    inValid2 = v2;
    inDat2   = d2;
    @(posedge sys_clk);
    edgeNo++;
    if (rst) begin
      doPop  = (mCnt > 0) && (edgeNo >= txFreeAt);
      doPush = v && (mCnt < DEPTH);
      if (doPop) begin
        sb.push_back('{mFifo.pop_front(), edgeNo});
        txFreeAt = edgeNo + FRAME1;
        lastPop  = edgeNo;
      end
      if (doPush) begin
        mFifo.push_back(d);
      end
      mCnt = mFifo.size();
    end
    #1;
    if (rst) begin
      checkOutput("fifoCount", int'(fifoCount), mCnt);
      checkOutput("inReady", int'(inReady), int'(mCnt < DEPTH));
      checkOutput("busy", int'(busy), int'((mCnt > 0) || (edgeNo < txFreeAt)));
    end
    if (rec2) begin
      hist2.push_back(txd2);
    end
    inDat  = 8'($urandom);
    inDat2 = 8'($urandom);
  endtask

  // Idle the inputs until the model and DUT have both finished, with a bound.
  task automatic drain();
    int n;
    n = 0;
    while ((mCnt > 0 || edgeNo < txFreeAt + 2 || busy) && n < 3000) begin
      applyStimulus(1'b0, 8'($urandom), 1'b0, 8'($urandom));
      n++;
    end
    checkOutput("drainTimeout", int'(n < 3000), 1);
  endtask

  // Serial monitor: decode every frame on txd and compare with the scoreboard.
  initial begin : monitor
    int         k;
    int         bad;
    int         expBit;
    bit         aborted;
    logic [7:0] got;
    exp_t       e;
    forever begin
      @(negedge sys_clk);
      if (rst && txd === 1'b0) begin
        k = edgeNo;
        startLog.push_back(k);
        checkOutput("frameExpected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
        end else begin
          e = '{8'h00, -1};
        end
        bad     = 0;
        got     = 8'h00;
        aborted = 0;
        for (int s = 0; s < FRAME1; s++) begin
          if (s > 0) begin
            @(negedge sys_clk);
            if (!rst) begin
              aborted = 1;
              break;
            end
          end
          if (s < OS) begin
            expBit = 0;
          end else if (s < 9 * OS) begin
            expBit = int'(e.dat[(s / OS) - 1]);
          end else begin
            expBit = 1;
          end
          if (txd !== expBit[0]) begin
            bad++;
          end
          if (s >= OS && s < 9 * OS && (s % OS) == OS / 2) begin
            got[(s / OS) - 1] = txd;
          end
        end
        if (!aborted) begin
          framesSeen++;
          checkOutput("frameData", int'(got), int'(e.dat));
          checkOutput("frameStartEdge", k, e.startEdge);
          checkOutput("frameBadSamples", bad, 0);
        end
      end
    end
  end

  // Hard stop in case something wedges the stimulus process.
  initial begin : watchdog
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : mainSeq
    int f0;
    int s0;
    int lows;
    int ones;
    int s1;
    int s2;
    int prob;

    rst      = 1'b0;
    inValid  = 1'b0;
    inDat    = 8'h00;
    inValid2 = 1'b0;
    inDat2   = 8'h00;

    // Reset state
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'hEE, 1'b1, 8'hEE);
    checkOutput("resetTxd", int'(txd), 1);
    checkOutput("resetBusy", int'(busy), 0);
    checkOutput("resetCount", int'(fifoCount), 0);
    checkOutput("resetReady", int'(inReady), 1);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    checkOutput("idleTxd", int'(txd), 1);

    // Single byte 0x55
    f0 = framesSeen;
    applyStimulus(1'b1, 8'h55, 1'b0, 8'h00);
    drain();
    checkOutput("singleFrames", framesSeen - f0, 1);

    // Back-to-back 0xA3, 0x0F
    f0 = framesSeen;
    s0 = startLog.size();
    applyStimulus(1'b1, 8'hA3, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'h0F, 1'b0, 8'h00);
    drain();
    checkOutput("b2bFrames", framesSeen - f0, 2);
    if (startLog.size() >= s0 + 2) begin
      checkOutput("b2bSpacing", startLog[s0 + 1] - startLog[s0], FRAME1);
    end else begin
      checkOutput("b2bStarts", startLog.size() - s0, 2);
    end

    // Full FIFO: six bytes offered back to back, only five fit
    f0 = framesSeen;
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 8'(i), 1'b0, 8'h00);
    checkOutput("fullReadyLow", int'(inReady), 0);
    drain();
    checkOutput("fullFrames", framesSeen - f0, 5);

    // Reset during data bit 3 of the first of two queued frames
    applyStimulus(1'b1, 8'h3C, 1'b0, 8'h00);
    applyStimulus(1'b1, 8'h81, 1'b0, 8'h00);
    for (int n = 0; n < 200 && edgeNo < lastPop + 4 * OS + 6; n++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    end
    checkOutput("midFrameReached", edgeNo, lastPop + 4 * OS + 6);
    #2;
    rst = 1'b0;
    #1;
    mFifo.delete();
    sb.delete();
    mCnt     = 0;
    txFreeAt = 0;
    checkOutput("rstTxd", int'(txd), 1);
    checkOutput("rstCount", int'(fifoCount), 0);
    checkOutput("rstReady", int'(inReady), 1);
    checkOutput("rstBusy", int'(busy), 0);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    rst  = 1'b1;
    f0   = framesSeen;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
      if (txd !== 1'b1) lows++;
    end
    checkOutput("noFrameAfterReset", lows, 0);
    checkOutput("framesAfterReset", framesSeen - f0, 0);

    // Two stop bits: two 0xFF frames on the second instance
    hist2.delete();
    rec2 = 1;
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hFF);
    applyStimulus(1'b0, 8'h00, 1'b1, 8'hFF);
    for (int i = 0; i < 420; i++) applyStimulus(1'b0, 8'h00, 1'b0, 8'h00);
    rec2 = 0;
    s1 = -1;
    s2 = -1;
    lows = 0;
    for (int i = 0; i < hist2.size(); i++) begin
      if (hist2[i] === 1'b0) begin
        lows++;
        if (s1 < 0) s1 = i;
        else if (s2 < 0 && i >= s1 + 9 * OS) s2 = i;
      end
    end
    checkOutput("stop2Lows", lows, 2 * OS);
    checkOutput("stop2Period", s2 - s1, FRAME2);
    ones = 0;
    if (s1 >= 0) begin
      for (int i = s1 + 9 * OS; i < s1 + FRAME2 && i < hist2.size(); i++) begin
        if (hist2[i] === 1'b1) ones++;
      end
    end
    checkOutput("stop2HighInterval", ones, 2 * OS);
    checkOutput("stop2BusyEnd", int'(busy2), 0);
    checkOutput("stop2CountEnd", int'(fifoCount2), 0);
    checkOutput("stop2ReadyEnd", int'(inReady2), 1);

    // Randomized traffic in phases of differing offered load
    f0 = framesSeen;
    for (int ph = 0; ph < 15; ph++) begin
      prob = (ph % 3 == 0) ? 5 : ((ph % 3 == 1) ? 40 : 100);
      for (int i = 0; i < 200; i++) begin
        applyStimulus(1'($urandom_range(99) < prob), 8'($urandom), 1'b0, 8'h00);
      end
    end
    drain();
    checkOutput("randomScoreboardEmpty", sb.size(), 0);
    checkOutput("randomSomeFrames", int'(framesSeen - f0 > 10), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
